// File: rtl/conv_window_buffer_pkg.sv
// Shared defaults, state encoding and helpers for the sliding-window tile buffer.
package conv_window_buffer_pkg;

  localparam int PIXEL_W_DEF = 4;
  localparam int TILE_N_DEF  = 4;
  localparam int WIN_K_DEF   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  typedef logic [PIXEL_W_DEF-1:0] pixel_t;

  // Width of a position index over p positions; never below one bit.
  function automatic int pos_width(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/conv_window_buffer_scan_counter.sv
// Raster-order window position counter over a P x P grid of window origins.
module window_scan_counter
  import conv_window_buffer_pkg::*;
#(
  parameter  int P  = 2,
  localparam int PW = pos_width(P)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clear,
  input  logic          advance,
  output logic [PW-1:0] row,
  output logic [PW-1:0] col,
  output logic          at_last
);

  localparam logic [PW-1:0] LAST_POS = PW'(P - 1);

  logic [PW-1:0] row_reg, row_next;
  logic [PW-1:0] col_reg, col_next;

  always_comb begin
    row_next = row_reg;
    col_next = col_reg;
    if (clear) begin
      row_next = '0;
      col_next = '0;
    end else if (advance) begin
      if (col_reg == LAST_POS) begin
        col_next = '0;
        row_next = row_reg + PW'(1);
      end else begin
        col_next = col_reg + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      row_reg <= '0;
      col_reg <= '0;
    end else begin
      row_reg <= row_next;
      col_reg <= col_next;
    end
  end

  assign row     = row_reg;
  assign col     = col_reg;
  // With a single position (P = 1) this is constantly true.
  assign at_last = (row_reg == LAST_POS) && (col_reg == LAST_POS);

endmodule

// File: rtl/conv_window_buffer.sv
// Double-banked tile buffer presenting a WIN_K x WIN_K window that slides over
// the active tile in raster order while the next tile waits in the shadow bank.
module conv_window_buffer
  import conv_window_buffer_pkg::*;
#(
  parameter  int PIXEL_W = PIXEL_W_DEF,
  parameter  int TILE_N  = TILE_N_DEF,
  parameter  int WIN_K   = WIN_K_DEF,
  localparam int P       = TILE_N - WIN_K + 1,
  localparam int PW      = pos_width(P)
) (
  input  logic                                        clk,
  input  logic                                        n_rst,
  input  logic                                        load_enable,
  input  logic                                        calc_done,
  input  logic [TILE_N-1:0][TILE_N-1:0][PIXEL_W-1:0] input_tile,
  output logic [WIN_K-1:0][WIN_K-1:0][PIXEL_W-1:0]   output_window,
  output logic                                        window_valid,
  output logic [PW-1:0]                               win_row,
  output logic [PW-1:0]                               win_col,
  output logic                                        last_window,
  output logic                                        tile_ready,
  output logic                                        load_overflow
);

  localparam int IDXW = (TILE_N > 1) ? $clog2(TILE_N) : 1;

  logic [TILE_N-1:0][TILE_N-1:0][PIXEL_W-1:0] active_reg;
  logic [TILE_N-1:0][TILE_N-1:0][PIXEL_W-1:0] shadow_reg;
  logic   shadow_full_reg, shadow_full_next;
  logic   overflow_reg, overflow_next;
  state_t state_reg, state_next;

  logic write_active, write_shadow, promote_shadow;
  logic cnt_clear, cnt_advance, at_last, accept;

  window_scan_counter #(.P(P)) u_scan (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .row     (win_row),
    .col     (win_col),
    .at_last (at_last)
  );

  assign accept = load_enable && !shadow_full_reg;

  always_comb begin
    state_next       = state_reg;
    shadow_full_next = shadow_full_reg;
    write_active     = 1'b0;
    write_shadow     = 1'b0;
    promote_shadow   = 1'b0;
    cnt_clear        = 1'b0;
    cnt_advance      = 1'b0;
    overflow_next    = load_enable && shadow_full_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          write_active = 1'b1;
          cnt_clear    = 1'b1;
          state_next   = SCAN;
        end
      end
      SCAN: begin
        if (calc_done && at_last) begin
          cnt_clear = 1'b1;
          if (shadow_full_reg) begin
            promote_shadow   = 1'b1;
            shadow_full_next = 1'b0;
          end else if (load_enable) begin
            // Shadow is empty, so the offer is accepted straight into active.
            write_active = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_advance = calc_done;
          if (accept) begin
            write_shadow     = 1'b1;
            shadow_full_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg       <= IDLE;
      active_reg      <= '0;
      shadow_reg      <= '0;
      shadow_full_reg <= 1'b0;
      overflow_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      shadow_full_reg <= shadow_full_next;
      overflow_reg    <= overflow_next;
      if (write_active) begin
        active_reg <= input_tile;
      end else if (promote_shadow) begin
        active_reg <= shadow_reg;
      end
      if (write_shadow) begin
        shadow_reg <= input_tile;
      end
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < WIN_K; gi++) begin : g_win_row
      logic [IDXW-1:0] r_idx;
      assign r_idx = IDXW'(win_row) + IDXW'(gi);
      for (gj = 0; gj < WIN_K; gj++) begin : g_win_col
        logic [IDXW-1:0] c_idx;
        assign c_idx = IDXW'(win_col) + IDXW'(gj);
        assign output_window[gi][gj] = active_reg[r_idx][c_idx];
      end
    end
  endgenerate

  assign window_valid  = (state_reg == SCAN);
  assign last_window   = window_valid && at_last;
  assign tile_ready    = !shadow_full_reg;
  assign load_overflow = overflow_reg;

endmodule

// File: tb/tb_conv_window_buffer.sv
// Directed bench for conv_window_buffer: default 4/3 geometry plus a 5/3 instance.
module tb_conv_window_buffer;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  // Default geometry: TILE_N = 4, WIN_K = 3, P = 2
  logic                   load_enable, calc_done;
  logic [3:0][3:0][3:0]   input_tile;
  logic [2:0][2:0][3:0]   output_window;
  logic                   window_valid, last_window, tile_ready, load_overflow;
  logic [0:0]             win_row, win_col;

  conv_window_buffer dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .load_enable   (load_enable),
    .calc_done     (calc_done),
    .input_tile    (input_tile),
    .output_window (output_window),
    .window_valid  (window_valid),
    .win_row       (win_row),
    .win_col       (win_col),
    .last_window   (last_window),
    .tile_ready    (tile_ready),
    .load_overflow (load_overflow)
  );

  // TILE_N = 5, WIN_K = 3, P = 3
  logic                   load_enable5, calc_done5;
  logic [4:0][4:0][3:0]   input_tile5;
  logic [2:0][2:0][3:0]   output_window5;
  logic                   window_valid5, last_window5, tile_ready5, load_overflow5;
  logic [1:0]             win_row5, win_col5;

  conv_window_buffer #(.PIXEL_W(4), .TILE_N(5), .WIN_K(3)) dut5 (
    .clk           (clk),
    .n_rst         (n_rst),
    .load_enable   (load_enable5),
    .calc_done     (calc_done5),
    .input_tile    (input_tile5),
    .output_window (output_window5),
    .window_valid  (window_valid5),
    .win_row       (win_row5),
    .win_col       (win_col5),
    .last_window   (last_window5),
    .tile_ready    (tile_ready5),
    .load_overflow (load_overflow5)
  );

  int checks = 0;
  int failures = 0;

  logic [3:0][3:0][3:0] tile_a, tile_b, tile_d;
  logic [4:0][4:0][3:0] tile_e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] win9(input int a, b, c, d, e, f, g, h, i);
    logic [2:0][2:0][3:0] w;
    w[0][0] = 4'(a); w[0][1] = 4'(b); w[0][2] = 4'(c);
    w[1][0] = 4'(d); w[1][1] = 4'(e); w[1][2] = 4'(f);
    w[2][0] = 4'(g); w[2][1] = 4'(h); w[2][2] = 4'(i);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        tile_a[r][c] = 4'((4 * r + c) % 16);
        tile_b[r][c] = 4'(15 - ((4 * r + c) % 16));
        tile_d[r][c] = 4'(r + c);
      end
    end
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        tile_e[r][c] = 4'((5 * r + c) % 16);
      end
    end

    n_rst = 1'b0;
    load_enable = 1'b0; calc_done = 1'b0; input_tile = '0;
    load_enable5 = 1'b0; calc_done5 = 1'b0; input_tile5 = '0;
    tick(); tick();

    // Values held during reset
    chk("rst_valid", 64'(window_valid), 64'd0);
    chk("rst_window", 64'(output_window), 64'd0);
    chk("rst_ready", 64'(tile_ready), 64'd1);
    chk("rst_ovf", 64'(load_overflow), 64'd0);
    chk("rst_last", 64'(last_window), 64'd0);
    n_rst = 1'b1;
    tick();
    chk("idle_valid", 64'(window_valid), 64'd0);

    // Tile A scan, ending in IDLE
    load_enable = 1'b1; input_tile = tile_a;
    tick();
    load_enable = 1'b0;
    chk("a_valid", 64'(window_valid), 64'd1);
    chk("a_pos00", 64'({win_row, win_col}), 64'h0);
    chk("a_win00", 64'(output_window), 64'(win9(0, 1, 2, 4, 5, 6, 8, 9, 10)));
    chk("a_last00", 64'(last_window), 64'd0);
    calc_done = 1'b1;
    tick();
    chk("a_pos01", 64'({win_row, win_col}), 64'h1);
    tick();
    chk("a_pos10", 64'({win_row, win_col}), 64'h2);
    tick();
    calc_done = 1'b0;
    chk("a_pos11", 64'({win_row, win_col}), 64'h3);
    chk("a_last11", 64'(last_window), 64'd1);
    chk("a_win11", 64'(output_window), 64'(win9(5, 6, 7, 9, 10, 11, 13, 14, 15)));
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    chk("a_end_valid", 64'(window_valid), 64'd0);
    chk("a_end_last", 64'(last_window), 64'd0);
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    chk("idle_calc_ignored", 64'(window_valid), 64'd0);

    // Shadow load, overflow, promotion
    load_enable = 1'b1; input_tile = tile_a;
    tick();
    input_tile = tile_b;
    tick();
    chk("b_ready0", 64'(tile_ready), 64'd0);
    chk("b_ovf0", 64'(load_overflow), 64'd0);
    chk("b_active_kept", 64'(output_window), 64'(win9(0, 1, 2, 4, 5, 6, 8, 9, 10)));
    input_tile = tile_a;
    tick();
    load_enable = 1'b0;
    chk("ovf_pulse", 64'(load_overflow), 64'd1);
    tick();
    chk("ovf_clear", 64'(load_overflow), 64'd0);
    calc_done = 1'b1;
    tick(); tick(); tick();
    calc_done = 1'b0;
    chk("b_pos_before", 64'({win_row, win_col}), 64'h3);
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    chk("b_valid", 64'(window_valid), 64'd1);
    chk("b_pos00", 64'({win_row, win_col}), 64'h0);
    chk("b_win00", 64'(output_window), 64'(win9(15, 14, 13, 11, 10, 9, 7, 6, 5)));
    chk("b_ready1", 64'(tile_ready), 64'd1);

    // Direct reload on the last window with shadow empty
    calc_done = 1'b1;
    tick(); tick(); tick();
    load_enable = 1'b1; input_tile = tile_a;
    tick();
    calc_done = 1'b0; load_enable = 1'b0;
    chk("direct_valid", 64'(window_valid), 64'd1);
    chk("direct_pos", 64'({win_row, win_col}), 64'h0);
    chk("direct_win", 64'(output_window), 64'(win9(0, 1, 2, 4, 5, 6, 8, 9, 10)));
    chk("direct_ready", 64'(tile_ready), 64'd1);

    // Load together with calc_done, then reset mid-scan
    load_enable = 1'b1; calc_done = 1'b1; input_tile = tile_b;
    tick();
    load_enable = 1'b0;
    chk("both_pos01", 64'({win_row, win_col}), 64'h1);
    chk("both_ready0", 64'(tile_ready), 64'd0);
    tick();
    calc_done = 1'b0;
    chk("pre_rst_pos10", 64'({win_row, win_col}), 64'h2);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(window_valid), 64'd0);
    chk("mid_rst_window", 64'(output_window), 64'd0);
    chk("mid_rst_ready", 64'(tile_ready), 64'd1);
    chk("mid_rst_pos", 64'({win_row, win_col}), 64'h0);
    chk("mid_rst_last", 64'(last_window), 64'd0);
    chk("mid_rst_ovf", 64'(load_overflow), 64'd0);
    tick();
    n_rst = 1'b1;
    tick();
    load_enable = 1'b1; input_tile = tile_d;
    tick();
    load_enable = 1'b0;
    chk("d_pos00", 64'({win_row, win_col}), 64'h0);
    chk("d_win00", 64'(output_window), 64'(win9(0, 1, 2, 1, 2, 3, 2, 3, 4)));
    calc_done = 1'b1;
    tick(); tick(); tick();
    chk("d_win11", 64'(output_window), 64'(win9(2, 3, 4, 3, 4, 5, 4, 5, 6)));
    tick();
    calc_done = 1'b0;
    chk("d_no_shadow", 64'(window_valid), 64'd0);

    // 5x5 tile with 3x3 window: nine positions
    load_enable5 = 1'b1; input_tile5 = tile_e;
    tick();
    load_enable5 = 1'b0;
    for (int k = 0; k < 9; k++) begin
      int er, ec;
      er = k / 3;
      ec = k % 3;
      chk($sformatf("t5_valid_%0d", k), 64'(window_valid5), 64'd1);
      chk($sformatf("t5_row_%0d", k), 64'(win_row5), 64'(er));
      chk($sformatf("t5_col_%0d", k), 64'(win_col5), 64'(ec));
      chk($sformatf("t5_last_%0d", k), 64'(last_window5), 64'(k == 8));
      chk($sformatf("t5_tl_%0d", k), 64'(output_window5[0][0]), 64'((5 * er + ec) % 16));
      chk($sformatf("t5_br_%0d", k), 64'(output_window5[2][2]),
          64'((5 * (er + 2) + ec + 2) % 16));
      calc_done5 = 1'b1;
      tick();
      calc_done5 = 1'b0;
    end
    chk("t5_end_valid", 64'(window_valid5), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
